// File: rtl/pipe_register.sv
// Elastic valid/ready pipeline register: DEPTH stages, each with a main and a skid slot.
// Upstream ready of every stage is a flop, so no combinational ready path crosses the chain.
module pipe_register #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              CNT_W     = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  logic             r_m_v [DEPTH];
  logic             r_s_v [DEPTH];
  logic [WIDTH-1:0] r_m_d [DEPTH];
  logic [WIDTH-1:0] r_s_d [DEPTH];
  logic [CNT_W-1:0] r_count;

  logic             w_up_v  [DEPTH];
  logic [WIDTH-1:0] w_up_d  [DEPTH];
  logic             w_dn_rdy[DEPTH];
  logic             w_acc   [DEPTH];
  logic             w_take  [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stg
    if (k == 0) begin : g_head
      assign w_up_v[k] = in_valid;
      assign w_up_d[k] = in_data;
    end else begin : g_body
      assign w_up_v[k] = r_m_v[k-1];
      assign w_up_d[k] = r_m_d[k-1];
    end

    if (k == DEPTH-1) begin : g_tail
      assign w_dn_rdy[k] = out_ready;
    end else begin : g_link
      assign w_dn_rdy[k] = ~r_s_v[k+1];
    end

    assign w_acc[k]  = w_up_v[k] & ~r_s_v[k];
    assign w_take[k] = r_m_v[k] & w_dn_rdy[k];

    // Skid drains into main before any new beat may land in main.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_m_v[k] <= 1'b0;
        r_s_v[k] <= 1'b0;
        r_m_d[k] <= RESET_VAL;
        r_s_d[k] <= RESET_VAL;
      end else if (flush) begin
        r_m_v[k] <= 1'b0;
        r_s_v[k] <= 1'b0;
      end else if (w_take[k]) begin
        if (r_s_v[k]) begin
          r_m_d[k] <= r_s_d[k];
          r_s_v[k] <= 1'b0;
        end else if (w_acc[k]) begin
          r_m_d[k] <= w_up_d[k];
        end else begin
          r_m_v[k] <= 1'b0;
        end
      end else if (w_acc[k]) begin
        if (r_m_v[k]) begin
          r_s_d[k] <= w_up_d[k];
          r_s_v[k] <= 1'b1;
        end else begin
          r_m_d[k] <= w_up_d[k];
          r_m_v[k] <= 1'b1;
        end
      end
    end
  end

  logic w_in_x;
  logic w_out_x;

  assign w_in_x  = w_acc[0] & ~rst;
  assign w_out_x = w_take[DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_in_x) - CNT_W'(w_out_x);
    end
  end

  assign in_ready  = ~r_s_v[0] & ~rst;
  assign out_valid = r_m_v[DEPTH-1];
  assign out_data  = r_m_d[DEPTH-1];
  assign count     = r_count;

endmodule
